// File: rtl/freq_analyzer_pkg.sv
// Shared definitions for the frequency-analyzer stimulus path: sequencer
// state encoding, blink half-period helper and default background value.
package freq_analyzer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_START,
        ST_RUN,
        ST_STOP,
        ST_DONE
    } seq_state_e;

    localparam logic [7:0] BACKGROUND_DEFAULT = 8'h10;
    localparam logic [7:0] PIX_ON             = 8'hFF;
    localparam logic [7:0] PIX_OFF            = 8'h00;

    // Clocks per half blink period; a zero frequency yields 0 so the
    // elaboration-time range check rejects it.
    function automatic int unsigned half_period(input int unsigned clk_hz,
                                                input int unsigned f_hz);
        if (f_hz == 0) return 0;
        return clk_hz / (2 * f_hz);
    endfunction

endpackage

// File: rtl/blink_toggler.sv
// Square-wave generator for one blinking pixel: toggles its level every
// HALF0 or HALF1 run cycles depending on sel.
module blink_toggler #(
    parameter int unsigned HALF0 = 1,
    parameter int unsigned HALF1 = 1
) (
    input  logic clock,
    input  logic aresetn,
    input  logic load,
    input  logic run,
    input  logic sel,
    output logic level
);

    if (HALF0 < 1 || HALF1 < 1) begin : g_bad_half
        $error("blink_toggler: half period must be at least 1 clock");
    end

    localparam logic [31:0] LIM0 = 32'(HALF0 - 1);
    localparam logic [31:0] LIM1 = 32'(HALF1 - 1);

    logic [31:0] cnt_q, cnt_d;
    logic        level_q, level_d;
    logic [31:0] lim;

    assign lim = sel ? LIM1 : LIM0;

    // Next count/level; >= so a switch to a shorter period that leaves the
    // count past the new limit still toggles on the next edge.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (load) begin
            cnt_d   = '0;
            level_d = 1'b0;
        end else if (run) begin
            if (cnt_q >= lim) begin
                cnt_d   = '0;
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    // Count and level registers; hold whenever neither load nor run.
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/blinking_pixel_generator.sv
// Synthetic pixel source with three blinking positions, plus the
// clear/start/stop control sequence consumed by the analyzer manager.
module blinking_pixel_generator
    import freq_analyzer_pkg::*;
#(
    parameter int unsigned LINE_LENGTH       = 1024,
    parameter int unsigned PIXEL0_INDEX      = 63,
    parameter int unsigned PIXEL1_INDEX      = 511,
    parameter int unsigned PIXEL2_INDEX      = 1023,
    parameter int unsigned PIXEL0_FREQUENCY0 = 5000,
    parameter int unsigned PIXEL0_FREQUENCY1 = 10000,
    parameter int unsigned PIXEL1_FREQUENCY0 = 15000,
    parameter int unsigned PIXEL1_FREQUENCY1 = 20000,
    parameter int unsigned PIXEL2_FREQUENCY0 = 25000,
    parameter int unsigned PIXEL2_FREQUENCY1 = 30000,
    parameter int unsigned CLOCK_FREQUENCY   = 100000000,
    parameter int unsigned RUN_CYCLES        = 100000000,
    parameter int unsigned STOP_HOLD         = 16,
    parameter logic [7:0]  BACKGROUND        = BACKGROUND_DEFAULT
) (
    input  logic       clock,
    input  logic       aresetn,
    input  logic       go,
    input  logic       abort,
    input  logic [2:0] freq_sel,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       clear,
    output logic       start,
    output logic       stop,
    output logic       busy,
    output logic       done
);

    if (STOP_HOLD < 7) begin : g_bad_stop
        $error("blinking_pixel_generator: STOP_HOLD must be at least 7");
    end
    if (LINE_LENGTH < 2) begin : g_bad_line
        $error("blinking_pixel_generator: LINE_LENGTH must be at least 2");
    end
    if (RUN_CYCLES < 1) begin : g_bad_run
        $error("blinking_pixel_generator: RUN_CYCLES must be at least 1");
    end

    localparam int unsigned HALF0_0 = half_period(CLOCK_FREQUENCY, PIXEL0_FREQUENCY0);
    localparam int unsigned HALF0_1 = half_period(CLOCK_FREQUENCY, PIXEL0_FREQUENCY1);
    localparam int unsigned HALF1_0 = half_period(CLOCK_FREQUENCY, PIXEL1_FREQUENCY0);
    localparam int unsigned HALF1_1 = half_period(CLOCK_FREQUENCY, PIXEL1_FREQUENCY1);
    localparam int unsigned HALF2_0 = half_period(CLOCK_FREQUENCY, PIXEL2_FREQUENCY0);
    localparam int unsigned HALF2_1 = half_period(CLOCK_FREQUENCY, PIXEL2_FREQUENCY1);

    localparam int unsigned     PIX_W    = $clog2(LINE_LENGTH);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(LINE_LENGTH - 1);
    localparam logic [PIX_W-1:0] IDX0     = PIX_W'(PIXEL0_INDEX);
    localparam logic [PIX_W-1:0] IDX1     = PIX_W'(PIXEL1_INDEX);
    localparam logic [PIX_W-1:0] IDX2     = PIX_W'(PIXEL2_INDEX);

    seq_state_e       state_q;
    logic [31:0]      run_cnt_q;
    logic [31:0]      stop_cnt_q;
    logic             clear_q, start_q, stop_q, busy_q, done_q, valid_q;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic [7:0]       data_q, data_d, pix_val;
    logic [2:0]       lvl;
    logic             streaming;

    assign streaming = (state_q == ST_RUN) || (state_q == ST_STOP);

    // Sequencer with registered control outputs, each set on the edge that
    // enters the state it belongs to.
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            run_cnt_q  <= '0;
            stop_cnt_q <= '0;
            clear_q    <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            clear_q <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: if (go) begin
                    state_q <= ST_CLEAR;
                    clear_q <= 1'b1;
                    busy_q  <= 1'b1;
                end
                ST_CLEAR: begin
                    state_q <= ST_START;
                    start_q <= 1'b1;
                end
                ST_START: begin
                    state_q   <= ST_RUN;
                    run_cnt_q <= '0;
                    valid_q   <= 1'b1;
                end
                ST_RUN: begin
                    // abort and terminal count share one exit path
                    if (abort || run_cnt_q == RUN_CYCLES - 1) begin
                        state_q    <= ST_STOP;
                        stop_q     <= 1'b1;
                        stop_cnt_q <= '0;
                    end else begin
                        run_cnt_q <= run_cnt_q + 32'd1;
                    end
                end
                ST_STOP: begin
                    if (stop_cnt_q == STOP_HOLD - 1) begin
                        state_q <= ST_DONE;
                        stop_q  <= 1'b0;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        stop_cnt_q <= stop_cnt_q + 32'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    blink_toggler #(.HALF0(HALF0_0), .HALF1(HALF0_1)) u_blink0 (
        .clock(clock), .aresetn(aresetn), .load(state_q == ST_START),
        .run(state_q == ST_RUN), .sel(freq_sel[0]), .level(lvl[0]));
    blink_toggler #(.HALF0(HALF1_0), .HALF1(HALF1_1)) u_blink1 (
        .clock(clock), .aresetn(aresetn), .load(state_q == ST_START),
        .run(state_q == ST_RUN), .sel(freq_sel[1]), .level(lvl[1]));
    blink_toggler #(.HALF0(HALF2_0), .HALF1(HALF2_1)) u_blink2 (
        .clock(clock), .aresetn(aresetn), .load(state_q == ST_START),
        .run(state_q == ST_RUN), .sel(freq_sel[2]), .level(lvl[2]));

    // Pixel value for the current position; checks run 2,1,0 so pixel 0
    // wins when indices coincide.
    always_comb begin
        pix_val = BACKGROUND;
        if (pix_q == IDX2) pix_val = lvl[2] ? PIX_ON : PIX_OFF;
        if (pix_q == IDX1) pix_val = lvl[1] ? PIX_ON : PIX_OFF;
        if (pix_q == IDX0) pix_val = lvl[0] ? PIX_ON : PIX_OFF;
    end

    // Next pixel position and next data word (data lags the counter by one).
    always_comb begin
        pix_d  = pix_q;
        data_d = streaming ? pix_val : 8'h00;
        if (state_q == ST_START) pix_d = '0;
        else if (streaming)      pix_d = (pix_q == LAST_PIX) ? '0 : pix_q + 1'b1;
    end

    // Pixel counter and registered data output.
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            pix_q  <= '0;
            data_q <= '0;
        end else begin
            pix_q  <= pix_d;
            data_q <= data_d;
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign clear      = clear_q;
    assign start      = start_q;
    assign stop       = stop_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_blinking_pixel_generator.sv
// Directed bench for blinking_pixel_generator with small timing parameters.
module tb_blinking_pixel_generator;

    logic       clock = 1'b0;
    logic       aresetn = 1'b0;
    logic       go = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] freq_sel = 3'b000;
    logic [7:0] data;
    logic       data_valid, clear, start, stop, busy, done;

    int n_chk = 0;
    int n_bad = 0;

    // pixel0 HALF 10/5, pixel1 HALF 20/10, pixel2 HALF 5/4
    blinking_pixel_generator #(
        .LINE_LENGTH(16), .PIXEL0_INDEX(3), .PIXEL1_INDEX(7), .PIXEL2_INDEX(15),
        .PIXEL0_FREQUENCY0(50), .PIXEL0_FREQUENCY1(100),
        .PIXEL1_FREQUENCY0(25), .PIXEL1_FREQUENCY1(50),
        .PIXEL2_FREQUENCY0(100), .PIXEL2_FREQUENCY1(125),
        .CLOCK_FREQUENCY(1000), .RUN_CYCLES(200), .STOP_HOLD(8),
        .BACKGROUND(8'h10)
    ) dut (
        .clock(clock), .aresetn(aresetn), .go(go), .abort(abort),
        .freq_sel(freq_sel), .data(data), .data_valid(data_valid),
        .clear(clear), .start(start), .stop(stop), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    // go pulse, then CLEAR, START and first RUN cycle; returns at RUN cycle 0
    task automatic start_run();
        go = 1'b1;
        cyc();
        go = 1'b0;
        chk("clear_hi", clear, 1);
        chk("busy_hi", busy, 1);
        chk("start_lo", start, 0);
        cyc();
        chk("clear_lo", clear, 0);
        chk("start_hi", start, 1);
        chk("dv_lo_start", data_valid, 0);
        cyc();
        chk("start_lo2", start, 0);
        chk("dv_hi_run0", data_valid, 1);
    endtask

    // Called inside STOP after n0 stop cycles seen; checks hold length and done
    task automatic finish_stop(input int n0);
        int n = n0;
        while (stop && n < 40) begin
            n++;
            cyc();
        end
        chk("stop_len", n, 8);
        chk("done_hi", done, 1);
        chk("busy_done", busy, 1);
        chk("dv_done", data_valid, 0);
        cyc();
        chk("done_lo", done, 0);
        chk("busy_lo", busy, 0);
        chk("data_idle", data, 0);
    endtask

    initial begin
        // reset values
        repeat (3) cyc();
        chk("rst_data", data, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_clear", clear, 0);
        chk("rst_start", start, 0);
        chk("rst_stop", stop, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        aresetn = 1'b1;
        cyc();

        // run 1: blink patterns, wrap, frequency switch at RUN cycle 7
        start_run();
        for (int rc = 0; rc < 200; rc++) begin
            case (rc)
                4:   chk("p0_c3", data, 8'h00);
                5:   chk("bg_c4", data, 8'h10);
                8:   chk("p1_c7", data, 8'h00);
                16:  chk("p2_c15", data, 8'hFF);
                17:  chk("wrap_p0", data, 8'h10);
                20:  chk("p0_c19", data, 8'hFF);
                24:  chk("p1_c23", data, 8'hFF);
                32:  chk("p2_c31", data, 8'h00);
                36:  chk("p0sw_c35", data, 8'h00);
                52:  chk("p0sw_c51", data, 8'hFF);
                68:  chk("p0sw_c67", data, 8'h00);
                199: chk("stop_lo_last", stop, 0);
                default: ;
            endcase
            if (rc == 7) freq_sel = 3'b001;
            cyc();
        end
        chk("stop_rise", stop, 1);
        chk("dv_stop", data_valid, 1);
        finish_stop(0);

        // run 2: abort at RUN cycle 50; go and abort during STOP ignored
        freq_sel = 3'b000;
        start_run();
        for (int rc = 0; rc <= 50; rc++) begin
            if (rc == 50) begin
                chk("abort_pre", stop, 0);
                abort = 1'b1;
            end
            cyc();
        end
        abort = 1'b0;
        chk("abort_stop", stop, 1);
        cyc();
        go = 1'b1;
        cyc();
        go = 1'b0;
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        finish_stop(3);
        cyc();
        chk("go_ign_busy", busy, 0);
        chk("go_ign_clear", clear, 0);

        // run 3: reset in mid-STOP
        start_run();
        repeat (200) cyc();
        chk("r3_stop", stop, 1);
        cyc();
        cyc();
        aresetn = 1'b0;
        #1;
        chk("arst_stop", stop, 0);
        chk("arst_busy", busy, 0);
        chk("arst_dv", data_valid, 0);
        chk("arst_data", data, 0);
        chk("arst_done", done, 0);
        cyc();
        aresetn = 1'b1;
        cyc();
        cyc();
        chk("post_rst_idle", busy, 0);

        // run 4: clean sequence after reset, pixel 0 at F0
        start_run();
        for (int rc = 0; rc < 200; rc++) begin
            case (rc)
                4:  chk("r4_p0_c3", data, 8'h00);
                36: chk("r4_p0_c35", data, 8'hFF);
                default: ;
            endcase
            cyc();
        end
        chk("r4_stop", stop, 1);
        finish_stop(0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/blinking_pixel_generator.md
Name: blinking_pixel_generator

Overview:
- Stimulus source for the frequency analyzer manager. Produces a synthetic pixel stream in which three pixel positions blink as square waves at selectable frequencies (F0 or F1 per pixel).
- Sequences the clear/start/stop control pulses that the manager consumes.
- Used on-chip for self-test and in benches as the transmitting end of the pixel/control interface.

Parameters:
- LINE_LENGTH, 1024: pixels per line; pixel counter wraps at LINE_LENGTH-1.
- PIXEL0_INDEX, 63: position of blinking pixel 0.
- PIXEL1_INDEX, 511: position of blinking pixel 1.
- PIXEL2_INDEX, 1023: position of blinking pixel 2.
- PIXEL0_FREQUENCY0 / PIXEL0_FREQUENCY1, 5000 / 10000 Hz: pixel 0 blink frequencies.
- PIXEL1_FREQUENCY0 / PIXEL1_FREQUENCY1, 15000 / 20000 Hz: pixel 1 blink frequencies.
- PIXEL2_FREQUENCY0 / PIXEL2_FREQUENCY1, 25000 / 30000 Hz: pixel 2 blink frequencies.
- CLOCK_FREQUENCY, 100000000: clock rate in Hz.
- RUN_CYCLES, 100000000: clocks spent in RUN.
- STOP_HOLD, 16: clocks stop is held high; must be at least 7.
- BACKGROUND, 8'h10: data value at non-blinking positions.

Ports:
- clock  in  1  sole clock.
- aresetn  in  1  asynchronous active-low reset.
- go  in  1  one-cycle request to start a run.
- abort  in  1  ends RUN early.
- freq_sel  in  3  bit k selects F1 (1) or F0 (0) for pixel k.
- data  out  8  pixel value.
- data_valid  out  1  pixel strobe.
- clear  out  1  analyzer clear pulse.
- start  out  1  start pulse.
- stop  out  1  stop level.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Interface: one clock (clock); reset is asynchronous, active-low (aresetn). All outputs are registered.
- Reset values: data=0, data_valid=0, clear=0, start=0, stop=0, busy=0, done=0; all counters 0; all blink levels 0; state IDLE.
- Half periods: HALFk_j = CLOCK_FREQUENCY/(2*PIXELk_FREQUENCYj), computed as localparams. Elaboration fails if any HALF is below 1.
- State machine: IDLE -> CLEAR -> START -> RUN -> STOP -> DONE -> IDLE.
  - IDLE: go=1 -> CLEAR. go outside IDLE is ignored.
  - CLEAR: clear=1 for exactly 1 cycle -> START.
  - START: start=1 for exactly 1 cycle. Pixel counter and all half-period counters load 0, blink levels load 0 -> RUN.
  - RUN: run counter counts 0..RUN_CYCLES-1, then -> STOP. abort=1 -> STOP on the next edge. If abort and the terminal count coincide, STOP is entered once.
  - STOP: stop=1 for exactly STOP_HOLD cycles. abort is ignored.
  - DONE: done=1 for 1 cycle -> IDLE.
- Pixel counter: advances in RUN and STOP; wraps LINE_LENGTH-1 -> 0.
- data_valid: 1 in RUN and STOP, else 0.
- data, one cycle after pixel counter value p:
  - p == PIXELk_INDEX: 8'hFF if blink level k is 1, else 8'h00.
  - otherwise: BACKGROUND.
  - not in RUN/STOP: 0.
- Index precedence: if index parameters coincide, pixel 0 takes precedence over 1, and 1 over 2.
- Blink counter k (32-bit) increments each RUN cycle.
  - On reaching HALFk_sel-1: level k toggles and the counter returns to 0.
  - A freq_sel change takes effect immediately. If the count is already at or above the new HALF-1, level k toggles on the next cycle and the counter clears.
- Blink counters and levels freeze in STOP and hold their values through DONE/IDLE until the next START.
- Reset mid-run: asynchronous return to IDLE; stop drops immediately.

Decomposition:
- Shared package freq_analyzer_pkg:
  - state encoding for the sequencer FSM;
  - HALF-period computation function;
  - BACKGROUND default.
- One sub-module: blink_toggler.
  - Parameters: HALF0, HALF1.
  - Ports: clock, aresetn, load, run, sel, level.
  - Instantiated three times.

Test Plan:
Common parameters: CLOCK_FREQUENCY=1000, PIXEL0_FREQUENCY0=50 (HALF=10), PIXEL0_FREQUENCY1=100 (HALF=5), LINE_LENGTH=16, indices 3/7/15, RUN_CYCLES=200, STOP_HOLD=8.
- Sequence: go after reset -> clear high 1 cycle, start high on the next cycle, data_valid rises on the cycle after that. After 200 RUN cycles stop is high for exactly 8 cycles, then done pulses 1 cycle, busy falls the same cycle.
- Pixel 0 blink at F0 (freq_sel=0): data at pixel 3 samples read 8'h00 for RUN cycles 0-9 and 8'hFF for cycles 10-19; all other positions read 8'h10.
- Frequency switch: freq_sel[0]=1 at RUN cycle 7 (count 7, which is above 4) -> level toggles at cycle 8, then every 5 cycles.
- Abort: abort at RUN cycle 50 -> stop rises next cycle, is held 8 cycles, done pulses once. A go during STOP is ignored.
- Reset: aresetn low in mid-STOP -> all outputs 0 asynchronously, state IDLE. A later go runs a full clean sequence.
- Wrap: pixel counter goes 15 -> 0. data at pixel 15 reflects level 2 and data at pixel 0 reads 8'h10.
